// File: rtl/bcd_addsub_pkg.sv
// Shared types and constants for the digit-serial signed-magnitude BCD adder/subtractor.
package bcd_addsub_pkg;

    localparam int BCD_MAX   = 9;
    localparam int BCD_RADIX = 10;
    localparam int NDIGITS   = 3;
    localparam int DIGIT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    // True when any digit of a packed 3-digit operand is outside 0..9.
    function automatic logic digits_invalid(input logic [NDIGITS*DIGIT_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (v[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX)) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_signmag_addsub_seq_digit.sv
// One BCD digit of add (x+y+cin) or subtract (x-y-cin), with decimal carry/borrow out.
module bcd_digit_addsub
    import bcd_addsub_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               cin,
    input  logic               sub,
    output logic [DIGIT_W-1:0] d,
    output logic               cout
);

    logic [DIGIT_W:0] w_sum;
    logic [DIGIT_W:0] w_diff;

    // Mod-16 correction works because every corrected digit lands in 0..9.
    always_comb begin
        w_sum  = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, cin};
        w_diff = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, cin};
        d      = w_sum[DIGIT_W-1:0];
        cout   = 1'b0;
        if (sub) begin
            d = w_diff[DIGIT_W-1:0];
            if (w_diff[DIGIT_W]) begin
                d    = w_diff[DIGIT_W-1:0] + DIGIT_W'(BCD_RADIX);
                cout = 1'b1;
            end
        end else if (w_sum > (DIGIT_W+1)'(BCD_MAX)) begin
            d    = w_sum[DIGIT_W-1:0] - DIGIT_W'(BCD_RADIX);
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_signmag_addsub_seq.sv
// Digit-serial signed-magnitude 3-digit BCD add/subtract, one digit per clock, LSD first.
module bcd_signmag_addsub_seq
    import bcd_addsub_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       op,
    input  logic       sign_a,
    input  logic       sign_b,
    input  logic [3:0] A2,
    input  logic [3:0] A1,
    input  logic [3:0] A0,
    input  logic [3:0] B2,
    input  logic [3:0] B1,
    input  logic [3:0] B0,
    input  logic       L,
    input  logic       E,
    input  logic       G,
    output logic [3:0] S2,
    output logic [3:0] S1,
    output logic [3:0] S0,
    output logic       cout,
    output logic       sign_s,
    output logic       err,
    output logic       busy,
    output logic       done
);

    localparam int W = NDIGITS * DIGIT_W;

    state_t         r_state, w_state_nxt;
    logic [1:0]     r_cnt;
    logic           r_c;
    logic           r_eff_sub, r_sign_a, r_sign_b, r_op, r_l, r_force_zero;
    logic [W-1:0]   r_x, r_y, r_res, r_s;
    logic           r_cout, r_sign, r_err;

    logic [W-1:0]   w_a, w_b, w_mag, w_res_fin;
    logic           w_bad, w_onehot, w_eff_sub, w_swap, w_accept;
    logic [DIGIT_W-1:0] w_d;
    logic           w_c, w_cout_fin, w_sign_raw, w_sign_fin;

    assign w_a       = {A2, A1, A0};
    assign w_b       = {B2, B1, B0};
    assign w_bad     = digits_invalid(w_a) | digits_invalid(w_b);
    assign w_onehot  = ({L, E, G} == 3'b100) | ({L, E, G} == 3'b010) | ({L, E, G} == 3'b001);
    assign w_eff_sub = sign_a ^ sign_b ^ op;
    assign w_swap    = w_eff_sub & L & w_onehot;
    assign w_accept  = (r_state == ST_IDLE) & start;

    bcd_digit_addsub u_digit (
        .x    (r_x[DIGIT_W-1:0]),
        .y    (r_y[DIGIT_W-1:0]),
        .cin  (r_c),
        .sub  (r_eff_sub),
        .d    (w_d),
        .cout (w_c)
    );

    // Final digit joins the two already shifted into r_res.
    assign w_mag      = {w_d, r_res[W-1:DIGIT_W]};
    assign w_res_fin  = r_force_zero ? '0 : w_mag;
    assign w_cout_fin = ~r_eff_sub & w_c & ~r_force_zero;
    assign w_sign_raw = (r_eff_sub & r_l) ? (r_sign_b ^ r_op) : r_sign_a;
    assign w_sign_fin = w_sign_raw & ~((w_res_fin == '0) & ~w_cout_fin);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = w_bad ? ST_DONE : ST_CALC;
            ST_CALC: if (r_cnt == 2'(NDIGITS - 1)) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_c          <= 1'b0;
            r_eff_sub    <= 1'b0;
            r_sign_a     <= 1'b0;
            r_sign_b     <= 1'b0;
            r_op         <= 1'b0;
            r_l          <= 1'b0;
            r_force_zero <= 1'b0;
            r_s          <= '0;
            r_cout       <= 1'b0;
            r_sign       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt        <= '0;
                r_c          <= 1'b0;
                r_eff_sub    <= w_eff_sub;
                r_sign_a     <= sign_a;
                r_sign_b     <= sign_b;
                r_op         <= op;
                r_l          <= L;
                r_force_zero <= ~w_onehot | (w_eff_sub & E);
                r_err        <= w_bad;
                if (w_bad) begin
                    r_s    <= '0;
                    r_cout <= 1'b0;
                    r_sign <= 1'b0;
                end
            end else if (r_state == ST_CALC) begin
                r_cnt <= r_cnt + 2'd1;
                r_c   <= w_c;
                if (r_cnt == 2'(NDIGITS - 1)) begin
                    r_s    <= w_res_fin;
                    r_cout <= w_cout_fin;
                    r_sign <= w_sign_fin;
                end
            end
        end
    end

    // Operand and partial-result shift registers carry no control meaning, so no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_x <= w_swap ? w_b : w_a;
            r_y <= w_swap ? w_a : w_b;
        end else if (r_state == ST_CALC) begin
            r_x   <= r_x >> DIGIT_W;
            r_y   <= r_y >> DIGIT_W;
            r_res <= {w_d, r_res[W-1:DIGIT_W]};
        end
    end

    assign {S2, S1, S0} = r_s;
    assign cout         = r_cout;
    assign sign_s       = r_sign;
    assign err          = r_err;
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);

endmodule

// File: tb/tb_bcd_signmag_addsub_seq.sv
// Bench for bcd_signmag_addsub_seq: directed table, integer reference model, control corner cases.
module tb_bcd_signmag_addsub_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, op = 1'b0, sign_a = 1'b0, sign_b = 1'b0;
    logic [3:0] A2 = 0, A1 = 0, A0 = 0, B2 = 0, B1 = 0, B0 = 0;
    logic       L = 1'b0, E = 1'b1, G = 1'b0;
    logic [3:0] S2, S1, S0;
    logic       cout, sign_s, err, busy, done;

    int n_vec = 0;
    int n_mis = 0;

    typedef struct {
        logic        op, sa, sb;
        logic [11:0] a, b;
        logic [11:0] s;
        logic        c, sg, e;
        int          lat;
    } vec_t;

    bcd_signmag_addsub_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .sign_a(sign_a), .sign_b(sign_b),
        .A2(A2), .A1(A1), .A0(A0), .B2(B2), .B1(B1), .B0(B0),
        .L(L), .E(E), .G(G),
        .S2(S2), .S1(S1), .S0(S0), .cout(cout), .sign_s(sign_s),
        .err(err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && start && !busy) assert ($onehot({L, E, G}));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int m);
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic int from_bcd(input logic [11:0] v);
        return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic bad_bcd(input logic [11:0] v);
        return (v[11:8] > 9) || (v[7:4] > 9) || (v[3:0] > 9);
    endfunction

    // Reference: signed integer arithmetic, then split back into sign/magnitude/carry digit.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int va, vb, res, m;
        r = v;
        r.lat = 3;
        if (bad_bcd(v.a) || bad_bcd(v.b)) begin
            r.s = 12'h000; r.c = 1'b0; r.sg = 1'b0; r.e = 1'b1; r.lat = 0;
            return r;
        end
        va  = v.sa ? -from_bcd(v.a) : from_bcd(v.a);
        vb  = v.sb ? -from_bcd(v.b) : from_bcd(v.b);
        res = v.op ? va - vb : va + vb;
        m   = (res < 0) ? -res : res;
        r.c  = (m >= 1000);
        r.s  = to_bcd(m % 1000);
        r.sg = (res < 0);
        r.e  = 1'b0;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        op = v.op; sign_a = v.sa; sign_b = v.sb;
        {A2, A1, A0} = v.a;
        {B2, B1, B0} = v.b;
        L = (v.a < v.b); E = (v.a == v.b); G = (v.a > v.b);
    endtask

    task automatic scramble();
        {A2, A1, A0, B2, B1, B0} = 24'($urandom);
        op = 1'($urandom); sign_a = 1'($urandom); sign_b = 1'($urandom);
        {L, E, G} = 3'b010;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin @(posedge clk); #1; n++; end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 10) begin @(posedge clk); #1; lat++; end
    endtask

    // Start one operation, then check latency, results and post-done holding.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        logic [11:0] s_hold;
        wait_idle();
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        wait_done(lat);
        chk({tag, ".lat"}, 32'(lat), 32'(v.lat));
        chk({tag, ".S"}, 32'({S2, S1, S0}), 32'(v.s));
        chk({tag, ".cout"}, 32'(cout), 32'(v.c));
        chk({tag, ".sign"}, 32'(sign_s), 32'(v.sg));
        chk({tag, ".err"}, 32'(err), 32'(v.e));
        s_hold = {S2, S1, S0};
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        chk({tag, ".hold"}, 32'({S2, S1, S0, cout, sign_s, err}),
            32'({s_hold, v.c, v.sg, v.e}));
    endtask

    function automatic vec_t mk(input logic o, sa, sb, input logic [11:0] a, b,
                                input logic [11:0] s, input logic c, sg, e, input int lat);
        vec_t v;
        v.op = o; v.sa = sa; v.sb = sb; v.a = a; v.b = b;
        v.s = s; v.c = c; v.sg = sg; v.e = e; v.lat = lat;
        return v;
    endfunction

    vec_t tbl[10];

    initial begin
        vec_t v;
        int   lat;
        logic saw_done;

        tbl[0] = mk(1, 0, 0, 12'h826, 12'h749, 12'h077, 0, 0, 0, 3);
        tbl[1] = mk(1, 0, 0, 12'h126, 12'h749, 12'h623, 0, 1, 0, 3);
        tbl[2] = mk(0, 1, 1, 12'h126, 12'h749, 12'h875, 0, 1, 0, 3);
        tbl[3] = mk(0, 0, 0, 12'h999, 12'h001, 12'h000, 1, 0, 0, 3);
        tbl[4] = mk(1, 0, 0, 12'h126, 12'h126, 12'h000, 0, 0, 0, 3);
        tbl[5] = mk(0, 0, 0, 12'h12A, 12'h100, 12'h000, 0, 0, 1, 0);
        tbl[6] = mk(0, 1, 1, 12'h999, 12'h001, 12'h000, 1, 1, 0, 3);
        tbl[7] = mk(1, 1, 1, 12'h500, 12'h200, 12'h300, 0, 1, 0, 3);
        tbl[8] = mk(1, 0, 1, 12'h200, 12'h300, 12'h500, 0, 0, 0, 3);
        tbl[9] = mk(0, 1, 0, 12'h050, 12'h050, 12'h000, 0, 0, 0, 3);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({S2, S1, S0, cout, sign_s, err, busy, done}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 40; i++) begin
            v.op = 1'($urandom); v.sa = 1'($urandom); v.sb = 1'($urandom);
            v.a = to_bcd($urandom_range(0, 999));
            v.b = ($urandom_range(0, 5) == 0) ? v.a : to_bcd($urandom_range(0, 999));
            if ($urandom_range(0, 7) == 0) v.b[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
            run_vec(model(v), $sformatf("rnd%0d", i));
        end

        // start pulsed while busy must be ignored, not queued
        run_vec(tbl[6], "pre_busy");
        @(negedge clk);
        drive(tbl[0]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        drive(tbl[3]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("busy_start.lat", 32'(lat), 32'd2);
        chk("busy_start.S", 32'({S2, S1, S0, cout}), 32'({12'h077, 1'b0}));
        saw_done = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (busy) saw_done = 1'b1; end
        chk("busy_start.not_queued", 32'(saw_done), 32'd0);

        // reset asserted during CALC aborts the operation
        @(negedge clk);
        drive(tbl[2]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_reset.outputs", 32'({S2, S1, S0, cout, sign_s, err, busy, done}), 32'd0);
        saw_done = 1'b0;
        repeat (2) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; if (done || busy) saw_done = 1'b1; end
        chk("mid_reset.no_done", 32'(saw_done), 32'd0);
        chk("mid_reset.held", 32'({S2, S1, S0, cout, sign_s}), 32'd0);

        // back-to-back: table run waits only until busy drops
        run_vec(tbl[1], "b2b_a");
        run_vec(tbl[2], "b2b_b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
